// File: rtl/fifo_write_scheduler_pkg.sv
// Shared definitions for the FIFO write-side scheduler and the read-side packet parser.
// Holds the state encoding, header field widths and the header packing helper.
package fifo_write_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam int HDR_CH_BITS  = 2;
   localparam int HDR_LEN_BITS = 6;
   // One extra bit so a full 64-byte burst length is representable.
   localparam int LEN_BITS     = HDR_LEN_BITS + 1;
   localparam logic [LEN_BITS-1:0] LEN_ONE = 1;

   // Header byte is {channel, length-1}; length 1..64 maps onto the 6-bit field.
   function automatic logic [7:0] pack_header(input logic [HDR_CH_BITS-1:0] ch,
                                              input logic [LEN_BITS-1:0]    len);
      return {ch, HDR_LEN_BITS'(len - LEN_ONE)};
   endfunction

endpackage

// File: rtl/fifo_write_scheduler_rr_arbiter_4.sv
// Four-way combinational round-robin arbiter.
// Picks the first requester after last_grant, wrapping modulo 4.
module rr_arbiter_4 (
   input  logic [3:0] req,
   input  logic [1:0] last_grant,
   output logic [1:0] grant,
   output logic       any_req
);

   logic [1:0] cand;
   logic       found;

   // Scan last_grant+1 .. last_grant+4; the first hit wins.
   always_comb begin
      grant = 2'd0;
      found = 1'b0;
      cand  = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         cand = last_grant + 2'(k);
         if (!found && req[cand]) begin
            grant = cand;
            found = 1'b1;
         end
      end
      any_req = found;
   end

endmodule

// File: rtl/fifo_write_scheduler.sv
// Write-side scheduler: round-robin grants among byte-stream sources and frames each
// burst as a header byte plus payload into the FIFO, honouring fifo_full combinationally.
module fifo_write_scheduler
   import fifo_write_scheduler_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int MAX_BURST = 32
) (
   input  logic                   clk_in,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_CH*8-1:0]    ch_avail,
   input  logic [NUM_CH*8-1:0]    ch_data,
   input  logic [NUM_CH-1:0]      ch_valid,
   output logic [NUM_CH-1:0]      ch_ready,
   input  logic                   fifo_full,
   output logic [7:0]             fifo_data,
   output logic                   fifo_write,
   output logic [HDR_CH_BITS-1:0] grant_ch,
   output logic                   busy,
   output logic [15:0]            pkt_count
);

   state_t                 state;
   state_t                 state_next;
   logic [HDR_CH_BITS-1:0] last_grant;
   logic [LEN_BITS-1:0]    len;
   logic [LEN_BITS-1:0]    remaining;
   logic [LEN_BITS-1:0]    len_sel;
   logic [3:0]             req;
   logic [1:0]             arb_grant;
   logic                   any_req;
   logic [7:0]             sel_avail;
   logic [7:0]             cur_data;
   logic                   cur_valid;
   logic                   xfer;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_req
      assign req[i] = |ch_avail[i*8 +: 8];
   end

   rr_arbiter_4 u_arb (
      .req        (req),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (any_req)
   );

   assign sel_avail = ch_avail[{arb_grant, 3'b000} +: 8];
   assign len_sel   = (sel_avail > 8'(MAX_BURST)) ? LEN_BITS'(MAX_BURST) : sel_avail[LEN_BITS-1:0];
   assign cur_data  = ch_data[{grant_ch, 3'b000} +: 8];
   assign cur_valid = ch_valid[grant_ch];
   assign xfer      = (state == ST_DATA) && cur_valid && !fifo_full;
   assign busy      = (state != ST_IDLE);

   // Write strobe and source accept are pure functions of state and fifo_full, so a
   // full FIFO blocks the write in the very cycle it is flagged.
   always_comb begin
      state_next = state;
      fifo_write = 1'b0;
      fifo_data  = 8'h00;
      ch_ready   = '0;
      case (state)
         ST_IDLE: begin
            if (enable && any_req) state_next = ST_HDR;
         end
         ST_HDR: begin
            fifo_write = !fifo_full;
            fifo_data  = pack_header(grant_ch, len);
            if (!fifo_full) state_next = ST_DATA;
         end
         ST_DATA: begin
            ch_ready[grant_ch] = !fifo_full;
            fifo_write         = xfer;
            fifo_data          = cur_data;
            if (xfer && remaining == LEN_ONE) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state      <= ST_IDLE;
         grant_ch   <= '0;
         last_grant <= HDR_CH_BITS'(NUM_CH - 1);
         len        <= '0;
         remaining  <= '0;
         pkt_count  <= 16'd0;
      end else begin
         state <= state_next;
         case (state)
            ST_IDLE: begin
               if (enable && any_req) begin
                  grant_ch <= arb_grant;
                  len      <= len_sel;
               end
            end
            ST_HDR: begin
               if (!fifo_full) remaining <= len;
            end
            ST_DATA: begin
               if (xfer) begin
                  remaining <= remaining - LEN_ONE;
                  if (remaining == LEN_ONE) begin
                     last_grant <= grant_ch;
                     pkt_count  <= pkt_count + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Self-checking bench for fifo_write_scheduler: a packet-level model predicts the FIFO
// byte stream, accepts and packet count every cycle; directed cases pin literal values.
module tb_fifo_write_scheduler;

   localparam int NUM_CH    = 4;
   localparam int MAX_BURST = 32;

   logic                clk_in;
   logic                reset;
   logic                enable;
   logic [NUM_CH*8-1:0] ch_avail;
   logic [NUM_CH*8-1:0] ch_data;
   logic [NUM_CH-1:0]   ch_valid;
   logic [NUM_CH-1:0]   ch_ready;
   logic                fifo_full;
   logic [7:0]          fifo_data;
   logic                fifo_write;
   logic [1:0]          grant_ch;
   logic                busy;
   logic [15:0]         pkt_count;

   typedef struct {
      logic [7:0] hdr;
      logic [1:0] ch;
      bit         is_hdr;
      bit         is_last;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  hdr_log[$];
   int          tb_avail[NUM_CH];
   int          src_ptr[NUM_CH];
   int          mptr[NUM_CH];
   logic [NUM_CH-1:0] hs;
   int          model_last;
   int          exp_pkt;
   int          wr_count;
   int          checks;
   int          failures;
   int          dur;
   int          wr_start;

   fifo_write_scheduler #(.NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .enable     (enable),
      .ch_avail   (ch_avail),
      .ch_data    (ch_data),
      .ch_valid   (ch_valid),
      .ch_ready   (ch_ready),
      .fifo_full  (fifo_full),
      .fifo_data  (fifo_data),
      .fifo_write (fifo_write),
      .grant_ch   (grant_ch),
      .busy       (busy),
      .pkt_count  (pkt_count)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Each source emits a deterministic byte sequence indexed by how many it has handed over.
   function automatic logic [7:0] src_byte(input int c, input int p);
      return 8'((c * 64 + p * 3 + 17) % 256);
   endfunction

   always_comb begin
      ch_avail = '0;
      ch_data  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_avail[i*8 +: 8] = 8'(tb_avail[i]);
         ch_data[i*8 +: 8]  = src_byte(i, src_ptr[i]);
      end
   end

   always @(posedge clk_in) begin
      #1;
      for (int i = 0; i < NUM_CH; i++)
         if (hs[i]) src_ptr[i] = src_ptr[i] + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int model_pick();
      for (int s = 1; s <= NUM_CH; s++) begin
         int c;
         c = (model_last + s) % NUM_CH;
         if (tb_avail[c] != 0) return c;
      end
      return -1;
   endfunction

   // Compare process: outputs are stable at the falling edge and are what the FIFO
   // and sources capture at the next rising edge.
   always @(negedge clk_in) begin
      logic       exp_write;
      logic [7:0] exp_data;
      logic [3:0] exp_ready;
      exp_write = 1'b0;
      exp_data  = 8'h00;
      exp_ready = 4'h0;
      hs = ch_valid & ch_ready;
      if (fifo_write) wr_count++;
      if (exp_q.size() > 0) begin
         if (exp_q[0].is_hdr) begin
            exp_write = !fifo_full;
            exp_data  = exp_q[0].hdr;
         end else begin
            exp_ready[exp_q[0].ch] = !fifo_full;
            exp_write = !fifo_full && ch_valid[exp_q[0].ch];
            exp_data  = src_byte(exp_q[0].ch, mptr[exp_q[0].ch]);
         end
         checkOutput("grant_ch", 32'(grant_ch), 32'(exp_q[0].ch));
      end
      checkOutput("fifo_write", 32'(fifo_write), 32'(exp_write));
      checkOutput("ch_ready", 32'(ch_ready), 32'(exp_ready));
      checkOutput("pkt_count", 32'(pkt_count), 32'(exp_pkt));
      if (exp_write) begin
         checkOutput("fifo_data", 32'(fifo_data), 32'(exp_data));
         if (exp_q[0].is_hdr) hdr_log.push_back(fifo_data);
         else mptr[exp_q[0].ch] = mptr[exp_q[0].ch] + 1;
         if (exp_q[0].is_last) exp_pkt = (exp_pkt + 1) % 65536;
         void'(exp_q.pop_front());
      end
   end

   task automatic applyStimulus(input int k, input logic [63:0] full_mask, input bit gaps, input int reset_at);
      fifo_full = (k < 64) ? full_mask[k] : 1'b0;
      ch_valid  = gaps ? {NUM_CH{(k % 2) == 1}} : '1;
      reset     = (k == reset_at);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk_in); #1;
      reset = 1'b0;
      exp_q.delete();
      hdr_log.delete();
      model_last = NUM_CH - 1;
      exp_pkt = 0;
   endtask

   // One packet: enable for the arbitration cycle, then run until busy drops.
   task automatic run_packet(input logic [63:0] full_mask, input bit gaps, input int reset_at, output int d);
      int   ch;
      int   len;
      int   k;
      exp_t e;
      ch  = model_pick();
      len = 0;
      if (ch >= 0) len = (tb_avail[ch] > MAX_BURST) ? MAX_BURST : tb_avail[ch];
      enable = 1'b1;
      applyStimulus(0, full_mask, gaps, reset_at);
      @(posedge clk_in); #1;
      enable = 1'b0;
      k = 1;
      if (ch >= 0) begin
         e.hdr = 8'(ch * 64 + len - 1); e.ch = 2'(ch); e.is_hdr = 1'b1; e.is_last = 1'b0;
         exp_q.push_back(e);
         for (int b = 0; b < len; b++) begin
            e.hdr = 8'h00; e.is_hdr = 1'b0; e.is_last = (b == len - 1);
            exp_q.push_back(e);
         end
         model_last = ch;
      end
      while (busy && k < 200) begin
         applyStimulus(k, full_mask, gaps, reset_at);
         @(posedge clk_in); #1;
         k++;
         if (reset) begin
            reset = 1'b0;
            exp_q.delete();
            model_last = NUM_CH - 1;
            exp_pkt = 0;
            break;
         end
      end
      fifo_full = 1'b0;
      ch_valid  = '1;
      d = k;
   endtask

   initial begin
      checks = 0; failures = 0; wr_count = 0; exp_pkt = 0; model_last = NUM_CH - 1;
      hs = '0;
      reset = 1'b1; enable = 1'b0; fifo_full = 1'b0; ch_valid = '1;
      for (int i = 0; i < NUM_CH; i++) begin
         tb_avail[i] = 0; src_ptr[i] = 0; mptr[i] = 0;
      end
      repeat (2) @(posedge clk_in);
      #1;
      do_reset();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_pkt", 32'(pkt_count), 32'd0);
      checkOutput("rst_grant", 32'(grant_ch), 32'd0);
      checkOutput("rst_write", 32'(fifo_write), 32'd0);
      checkOutput("rst_ready", 32'(ch_ready), 32'd0);

      $display("[TB] single packet");
      tb_avail[0] = 3;
      wr_start = wr_count;
      run_packet(64'h0, 1'b0, -1, dur);
      checkOutput("single_dur", 32'(dur), 32'd5);
      checkOutput("single_writes", 32'(wr_count - wr_start), 32'd4);
      checkOutput("single_pkt", 32'(pkt_count), 32'd1);
      checkOutput("single_busy", 32'(busy), 32'd0);
      checkOutput("single_hdr_n", 32'(hdr_log.size()), 32'd1);
      checkOutput("single_hdr", 32'(hdr_log[0]), 32'h02);

      $display("[TB] round robin");
      do_reset();
      for (int i = 0; i < NUM_CH; i++) tb_avail[i] = 1;
      for (int p = 0; p < 5; p++) run_packet(64'h0, 1'b0, -1, dur);
      checkOutput("rr_hdr_n", 32'(hdr_log.size()), 32'd5);
      checkOutput("rr_hdr0", 32'(hdr_log[0]), 32'h00);
      checkOutput("rr_hdr1", 32'(hdr_log[1]), 32'h40);
      checkOutput("rr_hdr2", 32'(hdr_log[2]), 32'h80);
      checkOutput("rr_hdr3", 32'(hdr_log[3]), 32'hC0);
      checkOutput("rr_hdr4", 32'(hdr_log[4]), 32'h00);
      checkOutput("rr_pkt", 32'(pkt_count), 32'd5);

      $display("[TB] burst cap");
      do_reset();
      tb_avail[0] = 0; tb_avail[1] = 0; tb_avail[2] = 100; tb_avail[3] = 1;
      wr_start = wr_count;
      run_packet(64'h0, 1'b0, -1, dur);
      checkOutput("burst_dur", 32'(dur), 32'd34);
      checkOutput("burst_writes", 32'(wr_count - wr_start), 32'd33);
      run_packet(64'h0, 1'b0, -1, dur);
      run_packet(64'h0, 1'b0, -1, dur);
      checkOutput("burst_hdr_n", 32'(hdr_log.size()), 32'd3);
      checkOutput("burst_hdr0", 32'(hdr_log[0]), 32'h9F);
      checkOutput("burst_hdr1", 32'(hdr_log[1]), 32'hC0);
      checkOutput("burst_hdr2", 32'(hdr_log[2]), 32'h9F);

      $display("[TB] backpressure");
      do_reset();
      tb_avail[2] = 0; tb_avail[3] = 0; tb_avail[1] = 4;
      wr_start = wr_count;
      run_packet(64'h0000_0000_0000_073F, 1'b0, -1, dur);
      checkOutput("bp_dur", 32'(dur), 32'd14);
      checkOutput("bp_writes", 32'(wr_count - wr_start), 32'd5);
      checkOutput("bp_hdr", 32'(hdr_log[0]), 32'h43);

      $display("[TB] valid gaps");
      do_reset();
      tb_avail[1] = 0; tb_avail[2] = 4;
      wr_start = wr_count;
      run_packet(64'h0, 1'b1, -1, dur);
      checkOutput("gap_dur", 32'(dur), 32'd10);
      checkOutput("gap_writes", 32'(wr_count - wr_start), 32'd5);
      checkOutput("gap_pkt", 32'(pkt_count), 32'd1);

      $display("[TB] reset mid packet");
      do_reset();
      tb_avail[2] = 0; tb_avail[1] = 5;
      wr_start = wr_count;
      run_packet(64'h0, 1'b0, 3, dur);
      checkOutput("mid_writes", 32'(wr_count - wr_start), 32'd3);
      checkOutput("mid_busy", 32'(busy), 32'd0);
      checkOutput("mid_pkt", 32'(pkt_count), 32'd0);
      checkOutput("mid_write", 32'(fifo_write), 32'd0);
      checkOutput("mid_hdr", 32'(hdr_log[0]), 32'h44);
      hdr_log.delete();
      tb_avail[0] = 2;
      run_packet(64'h0, 1'b0, -1, dur);
      checkOutput("post_hdr", 32'(hdr_log[0]), 32'h01);
      checkOutput("post_pkt", 32'(pkt_count), 32'd1);
      checkOutput("post_dur", 32'(dur), 32'd4);

      repeat (2) @(posedge clk_in);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_write_scheduler.md
Name: fifo_write_scheduler

Overview:
- Multi-channel write-side scheduler for the byte-wide, dual-clock tracking FIFO. It runs entirely in the FIFO write clock domain (clk_in).
- Arbitrates round-robin among NUM_CH byte-stream sources and frames each granted burst as a packet: one header byte, then 1..MAX_BURST payload bytes.
- Drives the FIFO write port (data_in/write_in) and honours the FIFO full flag exactly.

Parameters:
- NUM_CH, 4, number of source channels; fixed by the 2-bit channel id in the header.
- MAX_BURST, 32, maximum payload bytes per packet; legal range 1..64.

Ports:
- clk_in  input  1  FIFO write clock.
- reset  input  1  synchronous, active-high reset, clock clk_in.
- enable  input  1  allows new grants; an in-flight packet always completes.
- ch_avail  input  NUM_CH*8  per-channel count of bytes the source guarantees; channel i occupies bits [8i+7:8i].
- ch_data  input  NUM_CH*8  per-channel data byte, same packing as ch_avail.
- ch_valid  input  NUM_CH  per-channel data valid.
- ch_ready  output  NUM_CH  per-channel accept; combinational.
- fifo_full  input  1  FIFO full flag.
- fifo_data  output  8  byte to FIFO data_in; combinational.
- fifo_write  output  1  FIFO write_in strobe; combinational.
- grant_ch  output  2  channel currently granted; registered.
- busy  output  1  high when state is not IDLE.
- pkt_count  output  16  packets completed since reset; wraps at 65535 to 0.

Behaviour:
- Reset values:
  - state IDLE; grant_ch 0; last_grant NUM_CH-1, so channel 0 has first priority.
  - remaining 0; pkt_count 0; busy 0.
  - fifo_write 0 and all ch_ready 0 (both derive combinationally from state).
- Reset asserted mid-packet: abandons the packet immediately; no further header or payload writes occur. The FIFO is not rolled back.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - Eligible channel: ch_avail[i] != 0.
  - If enable=1 and any channel is eligible, select the first eligible channel scanning last_grant+1, +2, ... modulo NUM_CH.
  - Latch grant_ch. Latch len = min(ch_avail[sel], MAX_BURST). Go to HDR.
  - Arbitration takes exactly one cycle in IDLE.
- HDR:
  - fifo_write = !fifo_full; fifo_data = {grant_ch, len-1} (6-bit field).
  - On the cycle the write occurs, set remaining = len and go to DATA. Otherwise stall in HDR.
- DATA:
  - xfer = ch_valid[grant_ch] & !fifo_full.
  - ch_ready[grant_ch] = !fifo_full; all other ch_ready bits are 0.
  - fifo_write = xfer; fifo_data = ch_data[grant_ch].
  - On each xfer, remaining decrements.
  - On the xfer where remaining==1: go to IDLE, last_grant <= grant_ch, pkt_count increments.
  - A gap in ch_valid stalls DATA. No timeout; the source guarantees ch_avail bytes.
- fifo_write is never asserted while fifo_full=1. Because the path is combinational, full is exact and the FIFO never overruns.
- enable deasserted in HDR or DATA has no effect until the return to IDLE.
- Peak throughput: 1 byte/cycle. Per-packet overhead: 1 arbitration cycle plus 1 header cycle.
- ch_avail is sampled only in IDLE; changes during a packet are ignored.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=0, ST_HDR=1, ST_DATA=2.
  - HDR_CH_BITS=2 and HDR_LEN_BITS=6.
  - the header-packing function {ch, len-1}, which the read-side packet parser also uses.
- One sub-module: rr_arbiter_4. Inputs: request vector and last_grant. Outputs: grant index and any_req. Purely combinational.

Test Plan:
- Single packet: ch_avail[0]=3, valid held high, full=0, enable=1 -> writes 0x02, d0, d1, d2 on consecutive cycles after 1 IDLE cycle; pkt_count=1; busy falls.
- Round-robin: all four channels report ch_avail=1 -> headers 0x00, 0x40, 0x80, 0xC0 in that order; then channel 0 again.
- Burst cap: ch_avail[2]=100, MAX_BURST=32 -> header 0x9F, 32 payload bytes; next grant goes to another eligible channel before channel 2 is served again.
- Backpressure: fifo_full held high for 5 cycles in HDR, then for 3 cycles mid-payload -> fifo_write=0 and ch_ready=0 during those cycles; payload order and byte count unchanged.
- Valid gaps: ch_valid toggles every other cycle during a 4-byte packet -> exactly 4 payload writes; remaining reaches 0; no extra writes.
- Reset mid-DATA after 2 of 5 bytes -> next cycle fifo_write=0, state IDLE, pkt_count=0; the next grant goes to channel 0.
